// File: rtl/spatial_channel_sequencer_pkg.sv
// Shared constants, default geometry and FSM encodings for the spatial channel sequencer.
package spatial_channel_sequencer_pkg;

  localparam int unsigned SPATIAL_DIMENSION = 2048;
  localparam int unsigned CHANNEL_WIDTH     = 8;
  localparam int unsigned SPATIAL_WIDTH     = 16;

  localparam int unsigned DEFAULT_NUM_MODALITIES        = 3;
  localparam int unsigned DEFAULT_CHANNELS_PER_MODALITY = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } seq_state_e;

  // Index width for a counter that must hold values 0..n-1 (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spatial_channel_sequencer_if.sv
// Frame handshake, channel address, accumulator strobes and hypervector handshake.
// Optional SEQ_ABORT_EN adds Abort_SI / Aborted_SO.
interface spatial_channel_sequencer_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned MOD_WIDTH  = 2
);

  logic                  FrameValid_SI;
  logic                  FrameReady_SO;
  logic [ADDR_WIDTH-1:0] ChannelAddr_DO;
  logic                  Enable_SO;
  logic                  FirstHypervector_SO;
  logic                  StoreSecond_SO;
  logic                  XorFinal_SO;
  logic                  HvValid_SO;
  logic                  HvReady_SI;
  logic [MOD_WIDTH-1:0]  ModalityIdx_DO;
`ifdef SEQ_ABORT_EN
  logic                  Abort_SI;
  logic                  Aborted_SO;
`endif

  // Sequencer side
  modport master (
`ifdef SEQ_ABORT_EN
    input  Abort_SI,
    output Aborted_SO,
`endif
    input  FrameValid_SI,
    input  HvReady_SI,
    output FrameReady_SO,
    output ChannelAddr_DO,
    output Enable_SO,
    output FirstHypervector_SO,
    output StoreSecond_SO,
    output XorFinal_SO,
    output HvValid_SO,
    output ModalityIdx_DO
  );

  // Frame source / accumulator / consumer side
  modport slave (
`ifdef SEQ_ABORT_EN
    output Abort_SI,
    input  Aborted_SO,
`endif
    output FrameValid_SI,
    output HvReady_SI,
    input  FrameReady_SO,
    input  ChannelAddr_DO,
    input  Enable_SO,
    input  FirstHypervector_SO,
    input  StoreSecond_SO,
    input  XorFinal_SO,
    input  HvValid_SO,
    input  ModalityIdx_DO
  );

endinterface

// File: rtl/spatial_channel_sequencer_index_counter.sv
// seq_index_counter: nested channel/modality counter with a flat channel address.
// The flat address is kept as its own register and simply increments on every
// step, since the next modality's ch=0 directly follows the previous ch=C-1.
module seq_index_counter
  import spatial_channel_sequencer_pkg::*;
#(
  parameter int unsigned NUM_MODALITIES        = DEFAULT_NUM_MODALITIES,
  parameter int unsigned CHANNELS_PER_MODALITY = DEFAULT_CHANNELS_PER_MODALITY,
  parameter int unsigned ADDR_WIDTH            = 8,
  parameter int unsigned MOD_WIDTH             = 2,
  parameter int unsigned CH_WIDTH              = idx_width(CHANNELS_PER_MODALITY)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  step_ch_i,
  input  logic                  step_mod_i,
  output logic [CH_WIDTH-1:0]   ch_o,
  output logic [MOD_WIDTH-1:0]  mod_o,
  output logic                  last_ch_o,
  output logic                  last_mod_o,
  output logic [ADDR_WIDTH-1:0] addr_o
);

  logic [CH_WIDTH-1:0]   ch_q, ch_d;
  logic [MOD_WIDTH-1:0]  mod_q, mod_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  last_ch_q, last_ch_d;
  logic                  last_mod_q, last_mod_d;

  // Next index: clear wins, then modality step (resets ch), then channel step
  always_comb begin
    ch_d   = ch_q;
    mod_d  = mod_q;
    addr_d = addr_q;
    if (clear_i) begin
      ch_d   = '0;
      mod_d  = '0;
      addr_d = '0;
    end else if (step_mod_i) begin
      ch_d   = '0;
      mod_d  = mod_q + MOD_WIDTH'(1);
      addr_d = addr_q + ADDR_WIDTH'(1);
    end else if (step_ch_i) begin
      ch_d   = ch_q + CH_WIDTH'(1);
      addr_d = addr_q + ADDR_WIDTH'(1);
    end
    last_ch_d  = (ch_d == CH_WIDTH'(CHANNELS_PER_MODALITY - 1));
    last_mod_d = (mod_d == MOD_WIDTH'(NUM_MODALITIES - 1));
  end

  // Index registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ch_q       <= '0;
      mod_q      <= '0;
      addr_q     <= '0;
      last_ch_q  <= 1'b0;
      last_mod_q <= (NUM_MODALITIES == 1);
    end else begin
      ch_q       <= ch_d;
      mod_q      <= mod_d;
      addr_q     <= addr_d;
      last_ch_q  <= last_ch_d;
      last_mod_q <= last_mod_d;
    end
  end

  assign ch_o       = ch_q;
  assign mod_o      = mod_q;
  assign addr_o     = addr_q;
  assign last_ch_o  = last_ch_q;
  assign last_mod_o = last_mod_q;

endmodule

// File: rtl/spatial_channel_sequencer.sv
// Transmit-side sequencer for the spatial accumulator: walks a buffered frame
// modality by modality, issuing channel addresses and the accumulator strobes one
// cycle behind them, then presents each bundled hypervector via valid/ready.
// Optional macro SEQ_ABORT_EN adds a mid-frame abort with a one-cycle Aborted_SO pulse.
module spatial_channel_sequencer
  import spatial_channel_sequencer_pkg::*;
#(
  parameter int unsigned NUM_MODALITIES        = DEFAULT_NUM_MODALITIES,
  parameter int unsigned CHANNELS_PER_MODALITY = DEFAULT_CHANNELS_PER_MODALITY,
  parameter int unsigned ADDR_WIDTH            = 8,
  parameter int unsigned MOD_WIDTH             = 2
) (
  input  logic                         Clk_CI,
  input  logic                         Reset_RI,
  spatial_channel_sequencer_if.master  bus_if
);

  localparam int unsigned CH_WIDTH = idx_width(CHANNELS_PER_MODALITY);

  // Parameter legality
  if (CHANNELS_PER_MODALITY < 3) begin : g_chk_ch
    $error("CHANNELS_PER_MODALITY must be >= 3");
  end
  if (NUM_MODALITIES < 1) begin : g_chk_mod_cnt
    $error("NUM_MODALITIES must be >= 1");
  end
  if ((64'(1) << ADDR_WIDTH) < 64'(NUM_MODALITIES * CHANNELS_PER_MODALITY)) begin : g_chk_addr
    $error("ADDR_WIDTH too small for NUM_MODALITIES*CHANNELS_PER_MODALITY");
  end
  if ((64'(1) << MOD_WIDTH) < 64'(NUM_MODALITIES)) begin : g_chk_mod
    $error("MOD_WIDTH too small for NUM_MODALITIES");
  end

  seq_state_e state_q, state_d;
  logic frame_ready_q, frame_ready_d;
  logic en_q, en_d;
  logic first_q, first_d;
  logic second_q, second_d;
  logic final_q, final_d;
  logic hv_valid_q, hv_valid_d;
`ifdef SEQ_ABORT_EN
  logic aborted_q, aborted_d;
`endif

  logic                  clear_c, step_ch_c, step_mod_c;
  logic [CH_WIDTH-1:0]   ch;
  logic [MOD_WIDTH-1:0]  mod;
  logic                  last_ch, last_mod;
  logic [ADDR_WIDTH-1:0] addr;

  seq_index_counter #(
    .NUM_MODALITIES        (NUM_MODALITIES),
    .CHANNELS_PER_MODALITY (CHANNELS_PER_MODALITY),
    .ADDR_WIDTH            (ADDR_WIDTH),
    .MOD_WIDTH             (MOD_WIDTH),
    .CH_WIDTH              (CH_WIDTH)
  ) u_index (
    .clk_i      (Clk_CI),
    .rst_i      (Reset_RI),
    .clear_i    (clear_c),
    .step_ch_i  (step_ch_c),
    .step_mod_i (step_mod_c),
    .ch_o       (ch),
    .mod_o      (mod),
    .last_ch_o  (last_ch),
    .last_mod_o (last_mod),
    .addr_o     (addr)
  );

  // Next state, counter steps and next values of the registered strobes
  always_comb begin
    state_d    = state_q;
    en_d       = 1'b0;
    first_d    = 1'b0;
    second_d   = 1'b0;
    final_d    = 1'b0;
    clear_c    = 1'b0;
    step_ch_c  = 1'b0;
    step_mod_c = 1'b0;
`ifdef SEQ_ABORT_EN
    aborted_d  = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (bus_if.FrameValid_SI) begin
          state_d = ST_ISSUE;
          clear_c = 1'b1;
        end
      end
      ST_ISSUE: begin
        en_d     = 1'b1;
        first_d  = (ch == '0);
        second_d = (ch == CH_WIDTH'(1));
        final_d  = last_ch;
        if (last_ch) state_d = ST_DRAIN;
        else         step_ch_c = 1'b1;
      end
      ST_DRAIN: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (bus_if.HvReady_SI) begin
          if (last_mod) begin
            state_d = ST_IDLE;
          end else begin
            state_d    = ST_ISSUE;
            step_mod_c = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef SEQ_ABORT_EN
    if (bus_if.Abort_SI && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      en_d       = 1'b0;
      first_d    = 1'b0;
      second_d   = 1'b0;
      final_d    = 1'b0;
      step_ch_c  = 1'b0;
      step_mod_c = 1'b0;
      aborted_d  = 1'b1;
    end
`endif
    frame_ready_d = (state_d == ST_IDLE);
    hv_valid_d    = (state_d == ST_HOLD);
  end

  // FSM state and output registers with synchronous reset
  always_ff @(posedge Clk_CI) begin
    if (Reset_RI) begin
      state_q       <= ST_IDLE;
      frame_ready_q <= 1'b1;
      en_q          <= 1'b0;
      first_q       <= 1'b0;
      second_q      <= 1'b0;
      final_q       <= 1'b0;
      hv_valid_q    <= 1'b0;
`ifdef SEQ_ABORT_EN
      aborted_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      frame_ready_q <= frame_ready_d;
      en_q          <= en_d;
      first_q       <= first_d;
      second_q      <= second_d;
      final_q       <= final_d;
      hv_valid_q    <= hv_valid_d;
`ifdef SEQ_ABORT_EN
      aborted_q     <= aborted_d;
`endif
    end
  end

  assign bus_if.FrameReady_SO       = frame_ready_q;
  assign bus_if.ChannelAddr_DO      = addr;
  assign bus_if.Enable_SO           = en_q;
  assign bus_if.FirstHypervector_SO = first_q;
  assign bus_if.StoreSecond_SO      = second_q;
  assign bus_if.XorFinal_SO         = final_q;
  assign bus_if.HvValid_SO          = hv_valid_q;
  assign bus_if.ModalityIdx_DO      = mod;
`ifdef SEQ_ABORT_EN
  assign bus_if.Aborted_SO          = aborted_q;
`endif

endmodule

// File: tb/tb_spatial_channel_sequencer.sv
// Directed bench for spatial_channel_sequencer (3 modalities x 4 channels).
// Observed vector: {FrameReady, HvValid, XorFinal, StoreSecond, First, Enable, ModalityIdx[1:0], ChannelAddr[7:0]}.
module tb_spatial_channel_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  spatial_channel_sequencer_if #(.ADDR_WIDTH(8), .MOD_WIDTH(2)) sif ();

  spatial_channel_sequencer #(
    .NUM_MODALITIES        (3),
    .CHANNELS_PER_MODALITY (4),
    .ADDR_WIDTH            (8),
    .MOD_WIDTH             (2)
  ) dut (
    .Clk_CI   (clk),
    .Reset_RI (rst),
    .bus_if   (sif)
  );

  localparam logic [15:0] IDLE_RST = 16'h8000;

  function automatic logic [15:0] obs_vec();
    return {sif.FrameReady_SO, sif.HvValid_SO, sif.XorFinal_SO, sif.StoreSecond_SO,
            sif.FirstHypervector_SO, sif.Enable_SO, sif.ModalityIdx_DO, sif.ChannelAddr_DO};
  endfunction

  // Expected vector for cycle n after accept (HvReady held 1). Per modality m the
  // six cycles are: addr m*4+0..3 (strobes lag by one), drain, hold. Cycle 19+ is
  // IDLE with the last address (11) and modality (2) left in place.
  function automatic logic [15:0] exp_frame(input int n);
    int m, p;
    logic [7:0] a;
    if (n >= 19) return {1'b1, 1'b0, 4'b0000, 2'd2, 8'd11};
    m = (n - 1) / 6;
    p = (n - 1) % 6;
    a = 8'(m * 4 + ((p > 3) ? 3 : p));
    return {1'b0, (p == 5), (p == 4), (p == 2), (p == 1), (p >= 1 && p <= 4), 2'(m), a};
  endfunction

  // Raise FrameValid for one edge while idle; returns at cycle 1 of the frame
  task automatic accept_frame();
    @(negedge clk);
    sif.FrameValid_SI = 1'b1;
    @(negedge clk);
    sif.FrameValid_SI = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (obs_vec() !== IDLE_RST)
      $display("FAIL reset_values got %h want %h", obs_vec(), IDLE_RST);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (obs_vec() !== IDLE_RST)
      $display("FAIL idle_hold got %h want %h", obs_vec(), IDLE_RST);
    if (obs_vec() !== IDLE_RST) errors++;
  endtask

  task automatic test_single_frame();
    sif.HvReady_SI = 1'b1;
    accept_frame();
    for (int n = 1; n <= 19; n++) begin
      if (n > 1) @(negedge clk);
      checks++;
      if (obs_vec() !== exp_frame(n)) begin
        errors++;
        $display("FAIL single_frame cycle %0d got %h want %h", n, obs_vec(), exp_frame(n));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp;
    bit done;
    sif.HvReady_SI = 1'b0;
    accept_frame();
    for (int n = 1; n <= 12; n++) begin
      if (n > 1) @(negedge clk);
      if (n <= 6)       exp = exp_frame(n);
      else if (n <= 11) exp = exp_frame(6);
      else              exp = exp_frame(7);
      checks++;
      if (obs_vec() !== exp) begin
        errors++;
        $display("FAIL backpressure cycle %0d got %h want %h", n, obs_vec(), exp);
      end
      if (n == 11) sif.HvReady_SI = 1'b1;
    end
    done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sif.FrameReady_SO === 1'b1) begin
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_finish got %b want 1", done);
    end
  endtask

  task automatic test_frame_valid_ignored();
    sif.HvReady_SI = 1'b1;
    accept_frame();
    for (int n = 1; n <= 20; n++) begin
      if (n > 1) @(negedge clk);
      checks++;
      if (obs_vec() !== exp_frame(n)) begin
        errors++;
        $display("FAIL busy_frame_valid cycle %0d got %h want %h", n, obs_vec(), exp_frame(n));
      end
      if (n == 3) sif.FrameValid_SI = 1'b1;
      if (n == 4) sif.FrameValid_SI = 1'b0;
    end
  endtask

  task automatic test_reset_mid_issue();
    sif.HvReady_SI = 1'b1;
    accept_frame();
    for (int n = 1; n <= 3; n++) begin
      if (n > 1) @(negedge clk);
      checks++;
      if (obs_vec() !== exp_frame(n)) begin
        errors++;
        $display("FAIL pre_reset cycle %0d got %h want %h", n, obs_vec(), exp_frame(n));
      end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (obs_vec() !== IDLE_RST) begin
      errors++;
      $display("FAIL mid_issue_reset got %h want %h", obs_vec(), IDLE_RST);
    end
    accept_frame();
    for (int n = 1; n <= 19; n++) begin
      if (n > 1) @(negedge clk);
      checks++;
      if (obs_vec() !== exp_frame(n)) begin
        errors++;
        $display("FAIL post_reset_frame cycle %0d got %h want %h", n, obs_vec(), exp_frame(n));
      end
    end
  endtask

`ifdef SEQ_ABORT_EN
  task automatic test_abort();
    sif.HvReady_SI = 1'b1;
    accept_frame();
    for (int n = 1; n <= 8; n++) begin
      if (n > 1) @(negedge clk);
      checks++;
      if (obs_vec() !== exp_frame(n)) begin
        errors++;
        $display("FAIL pre_abort cycle %0d got %h want %h", n, obs_vec(), exp_frame(n));
      end
    end
    sif.Abort_SI = 1'b1;
    @(negedge clk);
    sif.Abort_SI = 1'b0;
    checks++;
    if ((obs_vec() & 16'hFC00) !== 16'h8000) begin
      errors++;
      $display("FAIL abort_ctrl got %h want %h", obs_vec() & 16'hFC00, 16'h8000);
    end
    checks++;
    if (sif.Aborted_SO !== 1'b1) begin
      errors++;
      $display("FAIL abort_pulse got %b want 1", sif.Aborted_SO);
    end
    sif.Abort_SI = 1'b1;
    @(negedge clk);
    sif.Abort_SI = 1'b0;
    checks++;
    if (sif.Aborted_SO !== 1'b0) begin
      errors++;
      $display("FAIL abort_pulse_width got %b want 0", sif.Aborted_SO);
    end
    @(negedge clk);
    checks++;
    if (sif.Aborted_SO !== 1'b0 || sif.FrameReady_SO !== 1'b1) begin
      errors++;
      $display("FAIL abort_in_idle got aborted=%b ready=%b want aborted=0 ready=1",
               sif.Aborted_SO, sif.FrameReady_SO);
    end
    accept_frame();
    checks++;
    if (obs_vec() !== exp_frame(1)) begin
      errors++;
      $display("FAIL post_abort_frame got %h want %h", obs_vec(), exp_frame(1));
    end
  endtask
`endif

  initial begin
    rst               = 1'b1;
    sif.FrameValid_SI = 1'b0;
    sif.HvReady_SI    = 1'b1;
`ifdef SEQ_ABORT_EN
    sif.Abort_SI      = 1'b0;
`endif
    test_reset();
    test_single_frame();
    test_backpressure();
    test_frame_valid_ignored();
    test_reset_mid_issue();
`ifdef SEQ_ABORT_EN
    test_abort();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spatial_channel_sequencer.md
Name: spatial_channel_sequencer

Overview:
- Transmit-side driver for the spatial accumulator. It walks the channels of a buffered feature frame modality by modality.
- It issues one channel address per cycle to the feature buffer and the item memory. Both have a 1-cycle read latency.
- It emits the accumulator control strobes (enable, first, store-second, xor-final) aligned to the returned data.
- After each modality it presents the bundled hypervector to the downstream consumer with a valid/ready handshake.

Parameters:
- NUM_MODALITIES, 3, number of modalities per frame.
- CHANNELS_PER_MODALITY, 4, channels bundled per modality. Must be >= 3; elaboration error otherwise.
- ADDR_WIDTH, 8, width of the flat channel address. Must satisfy 2^ADDR_WIDTH >= NUM_MODALITIES*CHANNELS_PER_MODALITY.
- MOD_WIDTH, 2, width of the modality index. Must satisfy 2^MOD_WIDTH >= NUM_MODALITIES.

Ports:
- Clk_CI  in  1  sole clock, rising edge.
- Reset_RI  in  1  synchronous, active-high reset.
- FrameValid_SI  in  1  upstream: full feature frame buffered.
- FrameReady_SO  out  1  sequencer idle and accepting a frame.
- ChannelAddr_DO  out  ADDR_WIDTH  flat channel index = mod*CHANNELS_PER_MODALITY + ch; drives feature buffer and item memory.
- Enable_SO  out  1  accumulator Enable_SI.
- FirstHypervector_SO  out  1  accumulator FirstHypervector_SI.
- StoreSecond_SO  out  1  accumulator store_second.
- XorFinal_SO  out  1  accumulator xor_final.
- HvValid_SO  out  1  accumulator output holds the finished modality hypervector.
- HvReady_SI  in  1  downstream consumed the hypervector.
- ModalityIdx_DO  out  MOD_WIDTH  modality currently being accumulated or presented.

Behaviour:
- Reset values: FrameReady_SO=1. Enable_SO, FirstHypervector_SO, StoreSecond_SO, XorFinal_SO and HvValid_SO all 0. ChannelAddr_DO=0, ModalityIdx_DO=0. State IDLE.
- Reset asserted in any state returns to these values on the next edge. No partial handshake survives.
- FSM states: IDLE, ISSUE, DRAIN, HOLD.
- IDLE: FrameReady_SO=1. FrameValid_SI&FrameReady_SO at an edge -> ISSUE with ch=0, mod=0. FrameReady_SO=0 in all other states; FrameValid_SI is ignored there.
- ISSUE: drive ChannelAddr_DO for (mod,ch) and increment ch each cycle. After issuing ch=CHANNELS_PER_MODALITY-1 -> DRAIN.
- Control stage: strobes are registered from the ISSUE cycle, so they appear exactly 1 cycle after the corresponding address.
  - Enable_SO=1 for every issued channel.
  - FirstHypervector_SO=1 only for ch=0.
  - StoreSecond_SO=1 only for ch=1.
  - XorFinal_SO=1 only for ch=CHANNELS_PER_MODALITY-1.
  - At most one of first/second/final is high in any cycle.
- DRAIN: one cycle, carrying the final channel's strobes. ChannelAddr_DO holds its last value -> HOLD.
- HOLD: HvValid_SO=1, Enable_SO=0, ChannelAddr_DO stable, ModalityIdx_DO=mod.
  - HvValid_SO stays high until HvReady_SI is sampled high.
  - On handshake with mod=NUM_MODALITIES-1 -> IDLE, FrameReady_SO=1 next cycle.
  - Otherwise mod+1, ch=0 -> ISSUE.
- Latency per modality: CHANNELS_PER_MODALITY issue cycles + 1 drain cycle + >=1 hold cycle.
- Minimum frame time: NUM_MODALITIES*(CHANNELS_PER_MODALITY+2) cycles.
- Counters never wrap mid-frame. The ch and mod counters are cleared on frame accept and by reset.
- HvReady_SI high outside HOLD has no effect.

Optional Feature:
- Macro: SEQ_ABORT_EN.
- With the macro: adds Abort_SI (in, 1) and Aborted_SO (out, 1).
  - Abort_SI sampled high in ISSUE, DRAIN or HOLD -> IDLE on the next edge. All strobes and HvValid_SO drop to 0, FrameReady_SO=1, and Aborted_SO pulses high for exactly 1 cycle.
  - Abort_SI in IDLE is ignored.
  - Reset takes priority over abort; no Aborted_SO pulse on reset.
- Without the macro: both ports are absent and behaviour is as above.

Decomposition:
- Shared constants header (alongside SPATIAL_DIMENSION, CHANNEL_WIDTH, SPATIAL_WIDTH): default NUM_MODALITIES and CHANNELS_PER_MODALITY, plus the FSM state encodings (2-bit).
- One sub-module: seq_index_counter, a nested ch/mod counter.
  - Inputs: clear, step_ch, step_mod.
  - Outputs: ch, mod, last_ch, last_mod and the flat address.

Test Plan:
All scenarios use NUM_MODALITIES=3, CHANNELS_PER_MODALITY=4.
1. Reset: hold Reset_RI 2 cycles -> FrameReady_SO=1, Enable_SO=0, HvValid_SO=0, ChannelAddr_DO=0, ModalityIdx_DO=0.
2. One frame, HvReady_SI tied 1, accepted at cycle 0:
   - ChannelAddr_DO=0,1,2,3 in cycles 1-4.
   - Enable_SO high in cycles 2-5: First@2, StoreSecond@3, XorFinal@5.
   - HvValid_SO@6 with ModalityIdx_DO=0; address 4 @7.
   - Modality 2 HvValid_SO@18; FrameReady_SO=1 @19.
3. Backpressure: HvReady_SI=0 for 5 cycles in modality 0 HOLD -> HvValid_SO held, Enable_SO=0, ChannelAddr_DO=3 stable; resumes with address 4 the cycle after HvReady_SI=1.
4. FrameValid_SI pulsed at cycle 3 of a busy frame -> ignored, frame completes exactly as in scenario 2.
5. Reset_RI asserted at cycle 3 (mid ISSUE) -> next cycle all strobes 0, FrameReady_SO=1; a new frame then runs exactly as in scenario 2.
6. With SEQ_ABORT_EN: Abort_SI at cycle 8 -> cycle 9 IDLE, Aborted_SO=1 for 1 cycle, HvValid_SO=0, Enable_SO=0.
